shift_reg_univ: RTL and testbench
=================================

// Module: shift_reg_univ
// PURPOSE
//  Parametrised universal shift register; successor to the fixed 8-bit SIPO chain.
//  Modes: shift left/right, rotate, parallel load and hold.
//  Counts shifts and flags each completed WIDTH-bit frame with a one-cycle pulse.
//  On that pulse it latches a stable parallel snapshot.
//  Serves as a SIPO deserialiser or PISO serialiser front-end for serial links.
// PARAMETERS
//  WIDTH      8   register length in bits; legal range >= 2
//  RESET_VAL  0   value loaded into q on reset (WIDTH bits)
//  CNT_W      $clog2(WIDTH)   derived localparam; width of bit_cnt
// PORTS
//  clk          in   1       clock; all logic on posedge
//  res          in   1       reset, synchronous, active-high
//  en           in   1       operation enable; 0 = hold all state
//  mode         in   2       shift_mode_e: 00 HOLD, 01 SHL, 10 SHR, 11 LOAD
//  rotate       in   1       1 = feed the end bit back instead of sin (SHL/SHR only)
//  sin          in   1       serial input
//  pin          in   WIDTH   parallel load data
//  q            out  WIDTH   live register contents
//  sout         out  1       serial output (end bit in the last shift direction)
//  pout         out  WIDTH   frame snapshot; updated only on frame completion
//  frame_valid  out  1       one-cycle pulse; pout holds a newly completed frame
//  bit_cnt      out  CNT_W   shifts taken in the current frame, 0..WIDTH-1
// BEHAVIOUR
//  - Reset: synchronous, active-high; res dominates en/mode. Reset values:
//    q=RESET_VAL, pout=0, frame_valid=0, bit_cnt=0, dir=LEFT, so sout=q[WIDTH-1].
//  - en=0 or mode=HOLD: q, pout, bit_cnt and dir hold; frame_valid=0.
//  - SHL: q <= {q[W-2:0], b}; b = rotate ? q[W-1] : sin; dir <= LEFT.
//  - SHR: q <= {b, q[W-1:1]}; b = rotate ? q[0] : sin; dir <= RIGHT.
//  - sout is combinational from q and the dir register:
//    dir==LEFT -> q[W-1]; dir==RIGHT -> q[0].
//  - LOAD: q <= pin; bit_cnt <= 0; dir unchanged; frame_valid=0 (a load is not a frame).
//  - bit_cnt: increments on every SHL/SHR edge, including rotates.
//    Wrap: a shift with bit_cnt==WIDTH-1 sets bit_cnt <= 0, frame_valid <= 1 and
//    pout <= the post-shift q value, all on that same edge.
//  - Latency: the first sin bit reaches q[W-1] after WIDTH SHL edges; the
//    8-cycle timing of the old 8-bit block is preserved at WIDTH=8.
//  - frame_valid is never high two cycles in a row unless back-to-back frames
//    occur, which requires WIDTH==1 (illegal). Otherwise it is 0 the cycle after a pulse.
//  - Direction change mid-frame does not clear bit_cnt; frames count shifts, not direction.
//  - Reset mid-frame discards the partial frame: bit_cnt=0, pout=0.
// STRUCTURE
//  - Package shift_reg_pkg: typedef enum logic[1:0] shift_mode_e {HOLD,SHL,SHR,LOAD};
//    typedef enum logic dir_e {LEFT,RIGHT}.
//  - One sub-module, shift_bit_cnt: mod-WIDTH counter.
//    Ports: clk, res, inc, clr, cnt, wrap (wrap = inc & cnt==WIDTH-1).
//  - Top level holds the datapath mux (mode/rotate), dir register and pout/frame_valid registers.
// TESTING (WIDTH=8 unless noted)
//  1 Reset: res=1 for 2 cycles with en=1, mode=SHL, sin=1 ->
//    q=00, pout=00, frame_valid=0, bit_cnt=0.
//  2 SIPO: SHL, sin=1,0,1,1,0,0,1,0 over 8 edges ->
//    q=8'hB2, frame_valid pulses for exactly 1 cycle, pout=8'hB2, bit_cnt=0.
//  3 PISO: LOAD 8'hA5, then 8x SHR with sin=0 ->
//    sout=1,0,1,0,0,1,0,1 (before each edge), q=00, frame_valid pulse on 8th.
//  4 Rotate: LOAD 8'h81, SHL rotate=1 -> 8'h03 after 1 edge, 8'h81 after 8 edges,
//    frame_valid pulse, pout=8'h81.
//  5 Hold/reset mid-frame: 5 SHL, en=0 for 3 cycles -> q, bit_cnt=5 stable;
//    then res=1 -> bit_cnt=0, and 8 further shifts are needed for frame_valid.
//  6 Load mid-frame plus WIDTH=16 instance: 3 SHL then LOAD 16'h1234 ->
//    bit_cnt=0, no pulse; next pulse only after 16 shifts.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register: operating modes and the
// remembered shift direction that selects which end bit drives sout.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHL  = 2'b01,
        SHR  = 2'b10,
        LOAD = 2'b11
    } shift_mode_e;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_e;

    // True for the modes that move data and therefore advance the frame count.
    function automatic logic is_shift(input shift_mode_e m);
        return (m == SHL) || (m == SHR);
    endfunction

endpackage

// File: rtl/shift_bit_cnt.sv
// Modulo-WIDTH shift counter. wrap marks the increment that completes a frame,
// so the owner can capture the frame on the same edge that the count rolls over.
module shift_bit_cnt #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign wrap = inc && (cnt_reg == LAST);
    assign cnt  = cnt_reg;

    // Next count: clear wins, otherwise step and roll over at the last position.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc) begin
            cnt_next = wrap ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (res) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: shift left/right (optionally rotating), parallel
// load and hold. Every WIDTH shifts a one-cycle frame_valid pulse is raised
// and the post-shift contents are captured in pout as a stable snapshot.
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter  int               WIDTH     = 8,
    parameter  logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int               CNT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  shift_mode_e      mode,
    input  logic             rotate,
    input  logic             sin,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic [WIDTH-1:0] pout,
    output logic             frame_valid,
    output logic [CNT_W-1:0] bit_cnt
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] pout_reg;
    logic             frame_valid_reg;
    dir_e             dir_reg;
    dir_e             dir_next;

    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;
    logic             b_left;
    logic             b_right;
    logic             inc;
    logic             clr;
    logic             wrap;

    // Bit entering the vacated end: the opposite end bit when rotating, else sin.
    assign b_left  = rotate ? q_reg[WIDTH-1] : sin;
    assign b_right = rotate ? q_reg[0]       : sin;

    // Per-bit wiring of the left- and right-shifted candidates.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lo
                assign shl_val[gi] = b_left;
            end else begin : g_lo_mid
                assign shl_val[gi] = q_reg[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_hi
                assign shr_val[gi] = b_right;
            end else begin : g_hi_mid
                assign shr_val[gi] = q_reg[gi+1];
            end
        end
    endgenerate

    // Mode decode: pick the next register value, direction and counter controls.
    always_comb begin
        q_next   = q_reg;
        dir_next = dir_reg;
        inc      = 1'b0;
        clr      = 1'b0;
        if (en) begin
            case (mode)
                SHL: begin
                    q_next   = shl_val;
                    dir_next = LEFT;
                    inc      = 1'b1;
                end
                SHR: begin
                    q_next   = shr_val;
                    dir_next = RIGHT;
                    inc      = 1'b1;
                end
                LOAD: begin
                    q_next = pin;
                    clr    = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    shift_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk  (clk),
        .res  (res),
        .inc  (inc),
        .clr  (clr),
        .cnt  (bit_cnt),
        .wrap (wrap)
    );

    // Datapath, direction and frame snapshot registers; the snapshot takes the
    // post-shift value so pout equals q on the cycle frame_valid is high.
    always_ff @(posedge clk) begin
        if (res) begin
            q_reg           <= RESET_VAL;
            dir_reg         <= LEFT;
            pout_reg        <= '0;
            frame_valid_reg <= 1'b0;
        end else begin
            q_reg           <= q_next;
            dir_reg         <= dir_next;
            frame_valid_reg <= wrap;
            if (wrap) begin
                pout_reg <= q_next;
            end
        end
    end

    assign q           = q_reg;
    assign pout        = pout_reg;
    assign frame_valid = frame_valid_reg;
    assign sout        = (dir_reg == LEFT) ? q_reg[WIDTH-1] : q_reg[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: WIDTH=8 and WIDTH=16 instances share stimulus.
// The driver updates a bit-level reference model and queues the expected
// post-edge state; a monitor pops and compares after each clock edge.
module tb_shift_reg_univ;
    import shift_reg_pkg::*;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        en = 1'b0;
    shift_mode_e mode = HOLD;
    logic        rotate = 1'b0;
    logic        sin = 1'b0;
    logic [15:0] pin = '0;

    logic [7:0]  q8, pout8;
    logic        sout8, fv8;
    logic [2:0]  cnt8;
    logic [15:0] q16, pout16;
    logic        sout16, fv16;
    logic [3:0]  cnt16;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] q;
        logic [15:0] pout;
        logic        fv;
        int          cnt;
        logic        sout;
    } exp_t;

    exp_t sb8[$];
    exp_t sb16[$];

    // Reference model state, index 0 -> WIDTH 8, index 1 -> WIDTH 16.
    logic [15:0] m_q[2];
    logic [15:0] m_pout[2];
    logic        m_fv[2];
    int          m_shifts[2];
    logic        m_left[2];

    always #5 clk = ~clk;

    shift_reg_univ #(.WIDTH(8)) dut8 (
        .clk(clk), .res(res), .en(en), .mode(mode), .rotate(rotate), .sin(sin),
        .pin(pin[7:0]), .q(q8), .sout(sout8), .pout(pout8),
        .frame_valid(fv8), .bit_cnt(cnt8)
    );

    shift_reg_univ #(.WIDTH(16)) dut16 (
        .clk(clk), .res(res), .en(en), .mode(mode), .rotate(rotate), .sin(sin),
        .pin(pin), .q(q16), .sout(sout16), .pout(pout16),
        .frame_valid(fv16), .bit_cnt(cnt16)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Apply one cycle of the specification's rules to model instance k.
    task automatic model_step(input int k, input int w);
        logic [15:0] mask;
        logic        b;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        if (res) begin
            m_q[k] = '0; m_pout[k] = '0; m_fv[k] = 1'b0;
            m_shifts[k] = 0; m_left[k] = 1'b1;
        end else if (!en || mode == HOLD) begin
            m_fv[k] = 1'b0;
        end else if (mode == LOAD) begin
            m_q[k] = pin & mask; m_shifts[k] = 0; m_fv[k] = 1'b0;
        end else begin
            if (mode == SHL) begin
                b = rotate ? m_q[k][w-1] : sin;
                m_q[k] = ((m_q[k] << 1) | {15'd0, b}) & mask;
                m_left[k] = 1'b1;
            end else begin
                b = rotate ? m_q[k][0] : sin;
                m_q[k] = (m_q[k] >> 1) | ({15'd0, b} << (w - 1));
                m_left[k] = 1'b0;
            end
            m_shifts[k]++;
            m_fv[k] = 1'b0;
            if (m_shifts[k] == w) begin
                m_shifts[k] = 0;
                m_fv[k] = 1'b1;
                m_pout[k] = m_q[k];
            end
        end
    endtask

    function automatic exp_t snap(input int k, input int w);
        exp_t e;
        e.q = m_q[k]; e.pout = m_pout[k]; e.fv = m_fv[k]; e.cnt = m_shifts[k];
        e.sout = m_left[k] ? m_q[k][w-1] : m_q[k][0];
        return e;
    endfunction

    // One clock: drive on the falling edge, queue expectations, wait past the rising edge.
    task automatic cyc(input logic r, input logic e, input shift_mode_e m,
                       input logic rot, input logic s, input logic [15:0] p);
        @(negedge clk);
        res = r; en = e; mode = m; rotate = rot; sin = s; pin = p;
        model_step(0, 8);
        model_step(1, 16);
        sb8.push_back(snap(0, 8));
        sb16.push_back(snap(1, 16));
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare every presented state against the queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb8.size() > 0) begin
            e = sb8.pop_front();
            check("w8_q", {8'd0, q8}, e.q);
            check("w8_pout", {8'd0, pout8}, e.pout);
            check("w8_fv", {15'd0, fv8}, {15'd0, e.fv});
            check("w8_cnt", {13'd0, cnt8}, 16'(e.cnt));
            check("w8_sout", {15'd0, sout8}, {15'd0, e.sout});
        end
        if (sb16.size() > 0) begin
            e = sb16.pop_front();
            check("w16_q", q16, e.q);
            check("w16_pout", pout16, e.pout);
            check("w16_fv", {15'd0, fv16}, {15'd0, e.fv});
            check("w16_cnt", {12'd0, cnt16}, 16'(e.cnt));
            check("w16_sout", {15'd0, sout16}, {15'd0, e.sout});
        end
    end

    logic [7:0] sipo_bits;
    logic [7:0] piso_exp;

    initial begin
        // 1 Reset dominates en/mode.
        cyc(1, 1, SHL, 0, 1, '0);
        cyc(1, 1, SHL, 0, 1, '0);
        check("reset_q", {8'd0, q8}, 16'h0000);
        check("reset_cnt", {13'd0, cnt8}, 16'h0000);

        // 2 SIPO: bits shifted in MSB first give 8'hB2.
        sipo_bits = 8'hB2;
        for (int i = 7; i >= 0; i--) begin
            cyc(0, 1, SHL, 0, sipo_bits[i], '0);
            if (i == 1) check("sipo_no_early_pulse", {15'd0, fv8}, 16'h0000);
        end
        check("sipo_q", {8'd0, q8}, 16'h00B2);
        check("sipo_pout", {8'd0, pout8}, 16'h00B2);
        check("sipo_fv", {15'd0, fv8}, 16'h0001);
        cyc(0, 1, HOLD, 0, 0, '0);
        check("sipo_fv_drop", {15'd0, fv8}, 16'h0000);

        // 3 PISO: LOAD A5, shift right; sout before each edge is LSB first.
        cyc(0, 1, LOAD, 0, 0, 16'h00A5);
        piso_exp = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            check("piso_sout", {15'd0, sout8}, {15'd0, piso_exp[i]});
            cyc(0, 1, SHR, 0, 0, '0);
        end
        check("piso_q", {8'd0, q8}, 16'h0000);
        check("piso_fv", {15'd0, fv8}, 16'h0001);

        // 4 Rotate left from 8'h81.
        cyc(0, 1, LOAD, 0, 0, 16'h0081);
        cyc(0, 1, SHL, 1, 0, '0);
        check("rot_first", {8'd0, q8}, 16'h0003);
        for (int i = 0; i < 7; i++) cyc(0, 1, SHL, 1, 0, '0);
        check("rot_q", {8'd0, q8}, 16'h0081);
        check("rot_pout", {8'd0, pout8}, 16'h0081);

        // 5 Hold then reset mid-frame.
        cyc(1, 0, HOLD, 0, 0, '0);
        for (int i = 0; i < 5; i++) cyc(0, 1, SHL, 0, 1, '0);
        for (int i = 0; i < 3; i++) cyc(0, 0, SHL, 0, 0, '0);
        check("hold_cnt", {13'd0, cnt8}, 16'h0005);
        cyc(1, 1, SHL, 0, 1, '0);
        check("midreset_cnt", {13'd0, cnt8}, 16'h0000);
        for (int i = 0; i < 8; i++) cyc(0, 1, SHR, 0, 1, '0);
        check("midreset_fv", {15'd0, fv8}, 16'h0001);

        // 6 Load mid-frame, 16-bit instance.
        cyc(1, 0, HOLD, 0, 0, '0);
        for (int i = 0; i < 3; i++) cyc(0, 1, SHL, 0, 1, '0);
        cyc(0, 1, LOAD, 0, 0, 16'h1234);
        check("load16_cnt", {12'd0, cnt16}, 16'h0000);
        check("load16_q", q16, 16'h1234);
        for (int i = 0; i < 15; i++) cyc(0, 1, SHL, 0, 0, '0);
        check("load16_no_pulse", {15'd0, fv16}, 16'h0000);
        cyc(0, 1, SHL, 0, 0, '0);
        check("load16_fv", {15'd0, fv16}, 16'h0001);

        // Randomized traffic, mostly enabled, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
                shift_mode_e'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 16'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
